// File: rtl/dkong3_vram_arb_pkg.sv
// Shared types for the VRAM arbiter: responder state encoding and tile RAM geometry.
package dkong3_pkg;

   localparam int VRAM_ADDR_W = 10;
   localparam int VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      DONE    = 2'd2
   } vram_arb_state_t;

endpackage

// File: rtl/dkong3_vram_arb_if.sv
// CPU strobes, video fetch port and tile RAM port of the VRAM arbiter.
interface dkong3_vram_arb_if
   import dkong3_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
);
   logic [ADDR_W-1:0] I_AB;
   logic [DATA_W-1:0] I_DB;
   logic              I_VRAM_RD_n;
   logic              I_VRAM_WR_n;
   logic              O_VRAMBUSY_n;
   logic [DATA_W-1:0] O_DB;
   logic              O_DB_OE_n;
   logic              I_FETCH_REQ;
   logic [ADDR_W-1:0] I_FETCH_ADDR;
   logic [DATA_W-1:0] O_FETCH_DATA;
   logic              O_FETCH_VALID;
   logic [ADDR_W-1:0] O_RAM_ADDR;
   logic              O_RAM_WE;
   logic [DATA_W-1:0] O_RAM_DIN;
   logic [DATA_W-1:0] I_RAM_DOUT;

   modport slave (
      input  I_AB, I_DB, I_VRAM_RD_n, I_VRAM_WR_n,
      input  I_FETCH_REQ, I_FETCH_ADDR, I_RAM_DOUT,
      output O_VRAMBUSY_n, O_DB, O_DB_OE_n,
      output O_FETCH_DATA, O_FETCH_VALID,
      output O_RAM_ADDR, O_RAM_WE, O_RAM_DIN
   );

   modport master (
      output I_AB, I_DB, I_VRAM_RD_n, I_VRAM_WR_n,
      output I_FETCH_REQ, I_FETCH_ADDR, I_RAM_DOUT,
      input  O_VRAMBUSY_n, O_DB, O_DB_OE_n,
      input  O_FETCH_DATA, O_FETCH_VALID,
      input  O_RAM_ADDR, O_RAM_WE, O_RAM_DIN
   );

endinterface

// File: rtl/dkong3_vram_arb.sv
// Arbitrates the 1Kx8 tile RAM between video fetch (fixed priority) and the CPU,
// holding VRAMBUSY_n low until the CPU access has completed.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no CPU access in flight; grant on strobe when video is quiet
//   RD_WAIT | read address presented last cycle; capture RAM data now
//   DONE    | access complete, busy released; wait for both strobes high
module dkong3_vram_arb
   import dkong3_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
)
(
   input  logic             I_CLK,
   input  logic             I_RESET,
   dkong3_vram_arb_if.slave bus
);

   vram_arb_state_t   state, state_nxt;
   logic              cpu_rd, cpu_wr, cpu_req, cpu_grant;
   logic [ADDR_W-1:0] addr_q, ram_addr;
   logic [DATA_W-1:0] db_q, fetch_data_q;
   logic              fetch_d1, fetch_valid_q;

   // a read strobe masks a simultaneous write strobe
   assign cpu_rd    = ~bus.I_VRAM_RD_n;
   assign cpu_wr    = ~bus.I_VRAM_WR_n & bus.I_VRAM_RD_n;
   assign cpu_req   = cpu_rd | cpu_wr;
   assign cpu_grant = cpu_req & ~bus.I_FETCH_REQ & (state == IDLE) & ~I_RESET;

   always_ff @(posedge I_CLK) begin
      if (I_RESET) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu_grant) state_nxt = cpu_wr ? DONE : RD_WAIT;
         end
         RD_WAIT: state_nxt = DONE;
         DONE: begin
            if (!cpu_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // the RAM port keeps its last address when nobody owns it
   always_comb begin
      ram_addr = addr_q;
      if (bus.I_FETCH_REQ)   ram_addr = bus.I_FETCH_ADDR;
      else if (cpu_grant)    ram_addr = bus.I_AB;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         addr_q        <= '0;
         db_q          <= '0;
         fetch_d1      <= 1'b0;
         fetch_data_q  <= '0;
         fetch_valid_q <= 1'b0;
      end else begin
         addr_q        <= ram_addr;
         if (state == RD_WAIT) db_q <= bus.I_RAM_DOUT;
         fetch_d1      <= bus.I_FETCH_REQ;
         if (fetch_d1) fetch_data_q <= bus.I_RAM_DOUT;
         fetch_valid_q <= fetch_d1;
      end
   end

   assign bus.O_RAM_ADDR    = ram_addr;
   assign bus.O_RAM_WE      = cpu_grant & cpu_wr;
   assign bus.O_RAM_DIN     = bus.I_DB;
   assign bus.O_VRAMBUSY_n  = ~(cpu_req & (state != DONE));
   assign bus.O_DB          = db_q;
   assign bus.O_DB_OE_n     = bus.I_VRAM_RD_n | (state != DONE);
   assign bus.O_FETCH_DATA  = fetch_data_q;
   assign bus.O_FETCH_VALID = fetch_valid_q;

endmodule
